apb_slave_mem: RTL
==================

Name: apb_slave_mem

Overview:
- APB responder paired with apb_master. Decodes SETUP/ACCESS phases and serves reads and writes to an internal register-array memory.
- Inserts a fixed, parameterised number of wait states before asserting Pready.
- Flags out-of-range addresses with Pslverr.
- Sits on the Paddr/Pwdata/Pwrite/Psel/Penable bus driven by apb_master and returns Prdata/Pready/Pslverr to it.

Parameters:
ADDR_WIDTH, 8, width of Paddr (matches `ADDR_WIDTH in apb_pkg)
DATA_WIDTH, 32, width of Pwdata/Prdata (matches `DATA_WIDTH in apb_pkg)
MEM_DEPTH, 64, number of DATA_WIDTH words; valid word index 0..MEM_DEPTH-1
WAIT_CYCLES, 2, access-phase cycles with Pready=0 before the ready cycle (0 = zero-wait)

Ports:
Pclk     input   1           clock, all state updates on rising edge
Presetn  input   1           asynchronous active-low reset
Psel     input   1           slave select from master
Penable  input   1           access-phase indicator
Pwrite   input   1           1=write, 0=read
Paddr    input   ADDR_WIDTH  word index (no byte-lane decoding)
Pwdata   input   DATA_WIDTH  write data
Prdata   output  DATA_WIDTH  read data, valid only in read ready cycle
Pready   output  1           transfer completion
Pslverr  output  1           error response, valid only with Pready=1

Behaviour:
- Reset (Presetn=0, asynchronous):
  - state=IDLE, wait counter=0, latched addr/write/wdata/err=0.
  - All MEM_DEPTH words cleared to 0.
  - Outputs while in reset: Pready=0, Pslverr=0, Prdata=0.
  - Reset asserted mid-access aborts the transfer with no memory update.
- State machine: IDLE, ACCESS.
- IDLE:
  - If Psel=1 and Penable=0 (setup phase): latch addr_q=Paddr, write_q=Pwrite, wdata_q=Pwdata, err_q=(Paddr>=MEM_DEPTH); load cnt=WAIT_CYCLES; go to ACCESS.
  - If Penable=1 without a preceding setup: protocol violation. Ignore it, stay in IDLE, Pready=0.
- ACCESS:
  - If Psel=0: abort, return to IDLE, no write.
  - Else if cnt!=0: cnt decrements by 1, Pready=0.
  - Else (cnt==0) this is the ready cycle: Pready=1, Pslverr=err_q. At the closing edge return to IDLE.
  - Write commit: mem[addr_q]<=wdata_q on the closing edge of the ready cycle, only if write_q=1, err_q=0, Psel=1 and Penable=1.
  - Read in the ready cycle: Prdata=mem[addr_q] when write_q=0 and err_q=0, else 0.
- Outputs:
  - Pready, Pslverr and Prdata are combinational decodes of registered state/counter/latched fields. No Psel/Penable/Paddr path reaches them, so there is no combinational loop with the master.
  - Pslverr=0 and Prdata=0 in every cycle where Pready=0.
- Latency: ready cycle is the (WAIT_CYCLES+1)th access cycle. Total transfer = WAIT_CYCLES+2 cycles including setup.
- Back-to-back: the cycle after the ready cycle is evaluated in IDLE. If the master presents Psel=1, Penable=0 there, a new transfer starts with no dead cycle.
- Read-after-write to the same address across back-to-back transfers returns the newly written data (commit precedes the next setup latch).
- Paddr/Pwrite/Pwdata changing during ACCESS is ignored; latched values are used.
- Error transfers:
  - Out-of-range write leaves memory unchanged.
  - Out-of-range read returns Prdata=0.
  - Both complete normally with Pslverr=1.

Test Plan:
- Reset then read addr 5 (WAIT_CYCLES=2) -> Pready=0 for 2 access cycles, then Pready=1, Prdata=0x00000000, Pslverr=0 in the 3rd access cycle.
- Write 0xDEADBEEF to addr 10, then back-to-back read addr 10 -> write completes with Pslverr=0; read returns Prdata=0xDEADBEEF; no idle cycle between the transfers.
- Write 0x12345678 to addr 64 (MEM_DEPTH=64), then read addr 64 -> both complete with Pready=1, Pslverr=1, Prdata=0. All 64 words stay unchanged (spot-check addr 0 and 63 = 0).
- Write 0xA5A5A5A5 to addr 3 with Psel dropped after 1 wait cycle, then read addr 3 -> write aborted, FSM back in IDLE, read returns 0x00000000.
- Write 0x0F0F0F0F to addr 7, assert Presetn=0 during the second wait cycle, release, read addr 7 -> Pready/Pslverr/Prdata=0 immediately on reset; read returns 0x00000000.
- Rebuild with WAIT_CYCLES=0; Penable=1 with no setup cycle, then a read of addr 1 -> the stray Penable produces no Pready; the read shows Pready=1 in the first access cycle.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB responder backed by a register-array memory.
// Inserts WAIT_CYCLES wait states per transfer and flags out-of-range word
// indices with Pslverr. All response outputs decode from registered state only.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  Pclk,
  input  logic                  Presetn,
  input  logic                  Psel,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_WIDTH-1:0] Paddr,
  input  logic [DATA_WIDTH-1:0] Pwdata,
  output logic [DATA_WIDTH-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]    CNT_LOAD  = CNT_W'(WAIT_CYCLES);
  // One extra bit so a depth equal to 2**ADDR_WIDTH still compares correctly
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  // Only the in-range index bits are kept; out-of-range is captured in err_q
  logic [IDX_W-1:0]       addr_q;
  logic                   write_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   err_q;
  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  logic                   setup;
  logic                   ready_cyc;
  logic                   commit;

  // Phase decodes shared by the FSM, the datapath and the outputs
  always_comb begin
    setup     = (state == IDLE) && Psel && !Penable;
    ready_cyc = (state == ACCESS) && (cnt == '0);
    commit    = ready_cyc && Psel && Penable && write_q && !err_q;
  end

  // Next-state logic: a setup opens an access, abort or ready cycle closes it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (setup) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!Psel)           state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Latch the transfer at setup and count down the wait states
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (setup) begin
      addr_q  <= Paddr[IDX_W-1:0];
      write_q <= Pwrite;
      wdata_q <= Pwdata;
      err_q   <= ({1'b0, Paddr} >= DEPTH_LIM);
      cnt     <= CNT_LOAD;
    end else if ((state == ACCESS) && Psel && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Memory array: cleared on reset, written on the closing edge of a good write
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Response outputs, quiet outside the ready cycle
  always_comb begin
    Pready  = ready_cyc;
    Pslverr = ready_cyc && err_q;
    Prdata  = '0;
    if (ready_cyc && !write_q && !err_q) Prdata = mem[addr_q];
  end

endmodule
